// File: rtl/prng_arbiter.sv
// Round-robin front end for a shared 16-bit LCG: one step per grant, two-stage
// output pipeline returning a tagged, permuted random byte to each requester.
module prng_arbiter #(
  parameter int          NUM_REQ    = 4,
  parameter logic [15:0] MULT       = 16'h5851,
  parameter logic [15:0] INC        = 16'h1405,
  parameter logic [15:0] RESET_SEED = 16'h0000,
  localparam int         ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               seed_load,
  input  logic [15:0]        seed_value,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [7:0]         rsp_data,
  output logic               busy
);

  typedef enum logic {
    RUN  = 1'b0,
    SEED = 1'b1
  } fsm_t;

  fsm_t              fsm, fsm_next;
  logic [15:0]       state;
  logic [ID_W-1:0]   rr_ptr;

  logic              grant_ok;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_idx;
  logic [ID_W-1:0]   cand;
  logic              do_grant;

  logic              s1_valid;
  logic [15:0]       s1_state;
  logic [ID_W-1:0]   s1_id;

  logic [15:0]       mix;
  logic [7:0]        xs;
  logic [2:0]        rot;
  logic [15:0]       dbl;
  logic [7:0]        byte_next;

  // A seed request overrides everything, including a second one during SEED.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    fsm_next = RUN;
    if (seed_load) fsm_next = SEED;
    grant_ok = !rst && (fsm == RUN) && !seed_load && enable;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= RUN;
    else     fsm <= fsm_next;
  end

  // Search starts one past the last winner, so the previous grantee ranks last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign do_grant = grant_ok && pick_valid;

  always_comb begin
    gnt = '0;
    if (do_grant) gnt[pick_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      state  <= RESET_SEED;
      rr_ptr <= ID_W'(NUM_REQ - 1);
    end else begin
      if (seed_load) begin
        state <= seed_value;
      end else if (do_grant) begin
        state  <= state * MULT + INC;
        rr_ptr <= pick_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_state <= '0;
      s1_id    <= '0;
    end else begin
      s1_valid <= do_grant;
      if (do_grant) begin
        s1_state <= state;
        s1_id    <= pick_idx;
      end
    end
  end

  // Output permutation: xorshift, keep bits [10:3], rotate right by the top three state bits.
  always_comb begin
    mix       = (s1_state >> 1) ^ s1_state;
    xs        = mix[10:3];
    rot       = s1_state[15:13];
    dbl       = {xs, xs} >> rot;
    byte_next = dbl[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id   <= s1_id;
        rsp_data <= byte_next;
      end
    end
  end

  assign busy = (fsm == SEED) || s1_valid || rsp_valid;

endmodule

// File: tb/tb_prng_arbiter.sv
// Self-checking bench for prng_arbiter: reference model plus response scoreboard,
// with directed scenarios checked against hand-derived constants.
module tb_prng_arbiter;

  localparam int NREQ = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        seed_load;
  logic [15:0] seed_value;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;

  prng_arbiter #(.NUM_REQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .seed_load  (seed_load),
    .seed_value (seed_value),
    .req        (req),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  logic [15:0] m_state;
  logic        m_seed;
  int          m_rr;
  logic        m_v1, m_v2;
  rsp_t        m_last;
  rsp_t        sb[$];

  // values sampled at the most recent tick
  logic [3:0]  obs_gnt;
  logic        obs_valid;
  logic [1:0]  obs_id;
  logic [7:0]  obs_data;
  logic        obs_busy;

  function automatic logic [7:0] scramble(input logic [15:0] s);
    logic [15:0] t;
    logic [7:0]  x;
    logic [15:0] w;
    t = ((s >> 1) ^ s) >> 3;
    x = t[7:0];
    w = {x, 8'h00} >> s[15:13];
    return w[15:8] | w[7:0];
  endfunction

  function automatic logic [15:0] lcg(input logic [15:0] s);
    int unsigned p;
    p = 32'(s) * 32'h5851 + 32'h1405;
    return p[15:0];
  endfunction

  task automatic model_reset();
    m_state = 16'h0000;
    m_seed  = 1'b0;
    m_rr    = NREQ - 1;
    m_v1    = 1'b0;
    m_v2    = 1'b0;
    m_last  = '0;
    sb.delete();
  endtask

  // One clock cycle: compare at negedge against the model, then advance the model.
  task automatic tick();
    logic [3:0] exp_gnt;
    logic       exp_busy;
    int         g_idx;
    int         c;
    @(negedge clk);
    if (rst) model_reset();
    exp_gnt = '0;
    g_idx   = -1;
    if (!rst && !m_seed && !seed_load && enable) begin
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_rr + k) % NREQ;
        if (g_idx < 0 && ((req >> c) & 4'b0001) != 4'b0000) g_idx = c;
      end
      if (g_idx >= 0) exp_gnt = 4'(32'd1 << g_idx);
    end
    exp_busy = m_seed || m_v1 || m_v2;

    n_cmp++;
    if (gnt !== exp_gnt) begin
      n_bad++;
      $display("FAIL gnt @%0t: got %b want %b", $time, gnt, exp_gnt);
    end
    n_cmp++;
    if (busy !== exp_busy) begin
      n_bad++;
      $display("FAIL busy @%0t: got %b want %b", $time, busy, exp_busy);
    end
    n_cmp++;
    if (rsp_valid !== m_v2) begin
      n_bad++;
      $display("FAIL rsp_valid @%0t: got %b want %b", $time, rsp_valid, m_v2);
    end
    if (m_v2) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard @%0t: response due but queue empty", $time);
      end else begin
        m_last = sb.pop_front();
      end
    end
    n_cmp++;
    if (rsp_id !== m_last.id || rsp_data !== m_last.data) begin
      n_bad++;
      $display("FAIL rsp @%0t: got id=%0d data=%h want id=%0d data=%h",
               $time, rsp_id, rsp_data, m_last.id, m_last.data);
    end

    obs_gnt   = gnt;
    obs_valid = rsp_valid;
    obs_id    = rsp_id;
    obs_data  = rsp_data;
    obs_busy  = busy;

    if (!rst) begin
      m_v2 = m_v1;
      m_v1 = (g_idx >= 0);
      if (g_idx >= 0) begin
        sb.push_back('{id: 2'(g_idx), data: scramble(m_state)});
        m_state = lcg(m_state);
        m_rr    = g_idx;
      end
      m_seed = seed_load;
      if (seed_load) m_state = seed_value;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    seed_load  = 1'b0;
    seed_value = 16'h0000;
    enable     = 1'b1;
    req        = 4'b0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    req = 4'b1111;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    n_cmp++;
    if (rsp_id !== 2'd0 || rsp_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_rsp: got id=%0d data=%h want 0/00", rsp_id, rsp_data);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    tick();
    req = 4'b0000;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_seed_sequence();
    logic [7:0] exp_seq [3];
    exp_seq = '{8'h00, 8'hC0, 8'h15};
    do_reset();
    seed_load  = 1'b1;
    seed_value = 16'h0000;
    tick();
    seed_load = 1'b0;
    req       = 4'b0001;
    tick();
    n_cmp++;
    if (obs_gnt !== 4'b0000) begin n_bad++; $display("FAIL seed_cycle_gnt: got %b want 0000", obs_gnt); end
    for (int i = 0; i < 5; i++) begin
      req = (i < 3) ? 4'b0001 : 4'b0000;
      tick();
      if (i < 3) begin
        n_cmp++;
        if (obs_gnt !== 4'b0001) begin n_bad++; $display("FAIL b2b_gnt[%0d]: got %b want 0001", i, obs_gnt); end
      end
      if (i >= 2) begin
        n_cmp++;
        if (obs_valid !== 1'b1 || obs_id !== 2'd0 || obs_data !== exp_seq[i-2]) begin
          n_bad++;
          $display("FAIL seq_rsp[%0d]: got v=%b id=%0d data=%h want v=1 id=0 data=%h",
                   i - 2, obs_valid, obs_id, obs_data, exp_seq[i-2]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [8];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) req = 4'b0000;
      tick();
      if (i < 8) begin
        n_cmp++;
        if (obs_gnt !== exp_g[i]) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, obs_gnt, exp_g[i]); end
      end
      if (i >= 2) begin
        n_cmp++;
        if (obs_valid !== 1'b1 || obs_id !== 2'((i - 2) % 4)) begin
          n_bad++;
          $display("FAIL rr_id[%0d]: got v=%b id=%0d want v=1 id=%0d", i - 2, obs_valid, obs_id, (i - 2) % 4);
        end
      end
    end
  endtask

  task automatic test_seed_with_req();
    do_reset();
    seed_load  = 1'b1;
    seed_value = 16'h0000;
    req        = 4'b0010;
    tick();
    n_cmp++;
    if (obs_gnt !== 4'b0000) begin n_bad++; $display("FAIL seed_req_gnt0: got %b want 0000", obs_gnt); end
    seed_load = 1'b0;
    tick();
    n_cmp++;
    if (obs_gnt !== 4'b0000) begin n_bad++; $display("FAIL seed_req_gnt1: got %b want 0000", obs_gnt); end
    tick();
    n_cmp++;
    if (obs_gnt !== 4'b0010) begin n_bad++; $display("FAIL seed_req_gnt2: got %b want 0010", obs_gnt); end
    req = 4'b0000;
    tick();
    tick();
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_id !== 2'd1 || obs_data !== 8'h00) begin
      n_bad++;
      $display("FAIL seed_req_rsp: got v=%b id=%0d data=%h want v=1 id=1 data=00", obs_valid, obs_id, obs_data);
    end
  endtask

  task automatic test_reseed_in_flight();
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    req        = 4'b0000;
    seed_load  = 1'b1;
    seed_value = 16'hBEEF;
    tick();
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_data !== 8'h00) begin
      n_bad++; $display("FAIL inflight0: got v=%b data=%h want v=1 data=00", obs_valid, obs_data);
    end
    seed_load = 1'b0;
    req       = 4'b0001;
    tick();
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_data !== 8'hC0 || obs_gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL inflight1: got v=%b data=%h gnt=%b want v=1 data=c0 gnt=0000", obs_valid, obs_data, obs_gnt);
    end
    tick();
    n_cmp++;
    if (obs_gnt !== 4'b0001) begin n_bad++; $display("FAIL post_seed_gnt: got %b want 0001", obs_gnt); end
    req = 4'b0000;
    tick();
    tick();
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_id !== 2'd0 || obs_data !== 8'h99) begin
      n_bad++;
      $display("FAIL post_seed_rsp: got v=%b id=%0d data=%h want v=1 id=0 data=99", obs_valid, obs_id, obs_data);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    req = 4'b0101;
    tick();
    tick();
    n_cmp++;
    if (obs_gnt !== 4'b0100) begin n_bad++; $display("FAIL en_gnt1: got %b want 0100", obs_gnt); end
    enable = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (obs_gnt !== 4'b0000 || obs_valid !== 1'b1 || obs_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL en_drain: got gnt=%b v=%b busy=%b want 0000/1/1", obs_gnt, obs_valid, obs_busy);
    end
    tick();
    n_cmp++;
    if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
      n_bad++; $display("FAIL en_idle: got v=%b busy=%b want 0/0", obs_valid, obs_busy);
    end
    enable = 1'b1;
    tick();
    n_cmp++;
    if (obs_gnt !== 4'b0001) begin n_bad++; $display("FAIL en_resume: got %b want 0001", obs_gnt); end
    req = 4'b0000;
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1111;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (gnt !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst: got gnt=%b v=%b busy=%b want 0000/0/0", gnt, rsp_valid, busy);
    end
    tick();
    req = 4'b0000;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL async_stale[%0d]: got v=%b want 0", i, obs_valid); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      seed_load  = ($urandom_range(0, 24) == 0);
      seed_value = 16'($urandom);
      enable     = ($urandom_range(0, 7) != 0);
      req        = 4'($urandom);
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL rand_drain: got %0d pending want 0", sb.size()); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_seed_sequence();
    test_round_robin();
    test_seed_with_req();
    test_reseed_in_flight();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prng_arbiter.md
Name: prng_arbiter

Overview:
- Shares one 16-bit PCG-style pseudo-random generator among NUM_REQ requesters, e.g. the VGA colour/sync dither lanes and the uio overlay.
- A round-robin arbiter issues at most one generator step per cycle, tags each 8-bit result with the requester ID and supports runtime reseeding.
- Sits between the per-lane effect logic and the shared generator datapath, so that every lane gets a distinct value and no lane starves.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MULT, 16'h5851, LCG multiplier.
- INC, 16'h1405, LCG increment.
- RESET_SEED, 16'h0000, generator state after reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  when low, no grants are issued; the pipeline still drains.
- seed_load  input  1  single-cycle request to load seed_value.
- seed_value  input  16  new generator state.
- req  input  NUM_REQ  per-requester level request.
- gnt  output  NUM_REQ  one-hot grant, valid for one cycle.
- rsp_valid  output  1  response strobe.
- rsp_id  output  clog2(NUM_REQ)  index of the requester being answered.
- rsp_data  output  8  random byte.
- busy  output  1  high while the FSM is in SEED or any pipeline stage is valid.

Behaviour:
- Reset is asynchronous and active-high:
  - state=RESET_SEED, FSM=RUN, rr_ptr=NUM_REQ-1.
  - All pipeline valid bits are 0.
  - gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- Reset asserted mid-operation discards all in-flight responses; none is emitted after release.
- FSM has two states: RUN and SEED.
  - RUN -> SEED when seed_load=1. In that cycle, state<=seed_value, gnt=0 and state is not advanced.
  - SEED -> RUN unconditionally after one cycle. No grant is issued in the SEED cycle.
  - seed_load in the SEED cycle reloads seed_value and stays in SEED.
- Grants are combinational from registered state: in RUN with enable=1 and req!=0, gnt selects the first set req bit searching from rr_ptr+1 upward, modulo NUM_REQ.
- On a grant:
  - rr_ptr<=granted index.
  - Stage-1 captures s=state and the ID.
  - state<=(state*MULT+INC) mod 2^16.
- Without a grant, state holds. Each reseed therefore gives a deterministic sequence.
- Stage 1 -> stage 2:
  - xs=(((s>>1)^s)>>3)[7:0], rot=s[15:13].
  - Stage 2 computes rsp_data=rotate-right(xs, rot) and registers it with the ID and a valid bit.
- Latency: grant in cycle T gives rsp_valid in cycle T+2. Throughput is one per cycle.
- Responses are in grant order. rsp_id and rsp_data hold their last values when rsp_valid=0.
- A requester holding req high gets back-to-back grants only if no other req is set.
- Fairness bound: every asserted req is granted within NUM_REQ grant cycles.
- Responses already in flight when seed_load arrives complete using the pre-seed states.
- seed_load and req in the same cycle: the seed wins and no grant is issued.
- enable falling mid-stream: no new grants; in-flight responses still complete.
- State wrap-around is a natural modulo-2^16 overflow, with no special case.

Test Plan:
- Reset, then seed_load with seed_value=16'h0000; hold req=4'b0001 for three grants -> rsp_data 8'h00, 8'hC0, 8'h15 at T+2, T+3 and T+4, all with rsp_id=0.
- req=4'b1111 held for 8 cycles after reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, ...; rsp_id sequence 0, 1, 2, 3, 0, ... two cycles later.
- Assert seed_load (seed 16'h0000) and req=4'b0010 in the same cycle -> gnt=0 for that cycle and the next. The first later grant returns 8'h00 with rsp_id=1.
- Grant twice, then reseed one cycle after the second grant -> both in-flight responses (8'h00, 8'hC0) are delivered. The post-seed first response equals the seed's first output.
- Drop enable with req=4'b0101 -> no gnt; rsp_valid drains after 2 cycles; busy falls. Re-raising enable resumes at the round-robin position.
- Assert rst asynchronously between clock edges with the pipeline full -> rsp_valid=0 and gnt=0 immediately; no response appears after release.
